// File: rtl/hazard_fwd_unit.sv
// Hazard detection and operand forwarding beside the decode/execute boundary.
// Keeps a shadow copy of in-flight destinations (EX plus FWD_STAGES later stages).
module hazard_fwd_unit #(
  parameter int XLEN             = 32,
  parameter int RA_W             = 5,
  parameter int NUM_RD_PORTS     = 2,
  parameter int FWD_STAGES       = 2,
  parameter int LOAD_READY_STAGE = 2,
  localparam int SEL_W           = $clog2(FWD_STAGES + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         id_valid,
  input  logic [NUM_RD_PORTS*RA_W-1:0] id_ra,
  input  logic [NUM_RD_PORTS-1:0]      id_ra_used,
  input  logic [RA_W-1:0]              id_wa,
  input  logic                         id_regwen,
  input  logic                         id_is_load,
  input  logic                         ex_redirect,
  input  logic [NUM_RD_PORTS*XLEN-1:0] ex_opnd_in,
  input  logic [FWD_STAGES*XLEN-1:0]   fwd_data,
  output logic [NUM_RD_PORTS*XLEN-1:0] ex_opnd_out,
  output logic [NUM_RD_PORTS*SEL_W-1:0] fwd_sel,
  output logic                         stall_fd,
  output logic                         flush_fd,
  output logic                         flush_de,
  output logic [31:0]                  stall_cnt,
  output logic [31:0]                  flush_cnt
);

  // Index 0 is the EX entry, index k is forwarding stage k.
  logic [FWD_STAGES:0]                 r_vld;
  logic [FWD_STAGES:0]                 r_rw;
  logic [FWD_STAGES:0][RA_W-1:0]       r_wa;
  logic [FWD_STAGES-1:0]               r_ld;
  logic [NUM_RD_PORTS-1:0][RA_W-1:0]   r_ex_ra;
  logic [NUM_RD_PORTS-1:0]             r_ex_used;
  logic [31:0]                         r_stall_cnt;
  logic [31:0]                         r_flush_cnt;

  logic                                w_lu;
  logic                                w_stall;
  logic                                w_bubble;
  logic [NUM_RD_PORTS-1:0][SEL_W-1:0]  w_sel;
  logic [NUM_RD_PORTS-1:0][XLEN-1:0]   w_opnd;

  // Descending search so the youngest matching producer is the one kept.
  always_comb begin
    w_sel  = '0;
    w_opnd = '0;
    for (int p = 0; p < NUM_RD_PORTS; p++) begin
      w_opnd[p] = ex_opnd_in[p*XLEN +: XLEN];
      if (r_ex_used[p] && r_ex_ra[p] != '0) begin
        for (int k = FWD_STAGES; k >= 1; k--) begin
          if (r_vld[k] && r_rw[k] && r_wa[k] == r_ex_ra[p]) begin
            w_sel[p]  = SEL_W'(k);
            w_opnd[p] = fwd_data[(k-1)*XLEN +: XLEN];
          end
        end
      end
    end
  end

  // A load at position q has its data forwardable only once it reaches LOAD_READY_STAGE.
  always_comb begin
    w_lu = 1'b0;
    for (int q = 0; q < FWD_STAGES; q++) begin
      if ((q + 1) < LOAD_READY_STAGE && r_vld[q] && r_rw[q] && r_ld[q]) begin
        for (int p = 0; p < NUM_RD_PORTS; p++) begin
          if (id_ra_used[p] && id_ra[p*RA_W +: RA_W] != '0 &&
              id_ra[p*RA_W +: RA_W] == r_wa[q])
            w_lu = 1'b1;
        end
      end
    end
  end

  assign w_stall  = id_valid & w_lu & ~ex_redirect;
  assign w_bubble = w_stall | ex_redirect;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vld       <= '0;
      r_rw        <= '0;
      r_wa        <= '0;
      r_ld        <= '0;
      r_ex_ra     <= '0;
      r_ex_used   <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      for (int k = 1; k <= FWD_STAGES; k++) begin
        r_vld[k] <= r_vld[k-1];
        r_rw[k]  <= r_rw[k-1];
        r_wa[k]  <= r_wa[k-1];
      end
      for (int k = 1; k < FWD_STAGES; k++)
        r_ld[k] <= r_ld[k-1];
      if (w_bubble) begin
        r_vld[0]  <= 1'b0;
        r_rw[0]   <= 1'b0;
        r_wa[0]   <= '0;
        r_ld[0]   <= 1'b0;
        r_ex_used <= '0;
      end else begin
        r_vld[0]  <= id_valid;
        r_rw[0]   <= id_regwen && (id_wa != '0);
        r_wa[0]   <= id_wa;
        r_ld[0]   <= id_is_load;
        r_ex_ra   <= id_ra;
        r_ex_used <= id_ra_used & {NUM_RD_PORTS{id_valid}};
      end
      if (w_stall && r_stall_cnt != '1)
        r_stall_cnt <= r_stall_cnt + 32'd1;
      if (ex_redirect && r_flush_cnt != '1)
        r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign ex_opnd_out = w_opnd;
  assign fwd_sel     = w_sel;
  assign stall_fd    = w_stall;
  assign flush_fd    = ex_redirect;
  assign flush_de    = ex_redirect;
  assign stall_cnt   = r_stall_cnt;
  assign flush_cnt   = r_flush_cnt;

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Bench for hazard_fwd_unit: directed pipeline scenarios followed by random traffic,
// all compared against a queue-based model of the in-flight instructions.
module tb_hazard_fwd_unit;
  localparam int XL = 32;
  localparam int AW = 5;
  localparam int NP = 2;
  localparam int FS = 2;
  localparam int LR = 2;
  localparam int SW = $clog2(FS + 1);

  logic               clk = 1'b0;
  logic               rst;
  logic               id_valid;
  logic [NP*AW-1:0]   id_ra;
  logic [NP-1:0]      id_ra_used;
  logic [AW-1:0]      id_wa;
  logic               id_regwen;
  logic               id_is_load;
  logic               ex_redirect;
  logic [NP*XL-1:0]   ex_opnd_in;
  logic [FS*XL-1:0]   fwd_data;
  logic [NP*XL-1:0]   ex_opnd_out;
  logic [NP*SW-1:0]   fwd_sel;
  logic               stall_fd;
  logic               flush_fd;
  logic               flush_de;
  logic [31:0]        stall_cnt;
  logic [31:0]        flush_cnt;

  hazard_fwd_unit #(.XLEN(XL), .RA_W(AW), .NUM_RD_PORTS(NP), .FWD_STAGES(FS),
                    .LOAD_READY_STAGE(LR)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_ra(id_ra), .id_ra_used(id_ra_used),
    .id_wa(id_wa), .id_regwen(id_regwen), .id_is_load(id_is_load),
    .ex_redirect(ex_redirect), .ex_opnd_in(ex_opnd_in), .fwd_data(fwd_data),
    .ex_opnd_out(ex_opnd_out), .fwd_sel(fwd_sel), .stall_fd(stall_fd),
    .flush_fd(flush_fd), .flush_de(flush_de), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Model: one instruction record in EX, a queue of older ones (front = stage 1).
  typedef struct packed { bit v; bit [AW-1:0] wa; bit rw; bit ld; } ent_t;
  ent_t          m_ex;
  ent_t          m_st[$];
  bit [AW-1:0]   m_ra [NP];
  bit            m_used [NP];
  bit [31:0]     m_scnt, m_fcnt;
  bit            e_stall;

  task automatic m_reset();
    m_ex = '0;
    m_st = {};
    for (int i = 0; i < FS; i++) m_st.push_back('0);
    for (int p = 0; p < NP; p++) begin m_ra[p] = '0; m_used[p] = 1'b0; end
    m_scnt = '0;
    m_fcnt = '0;
  endtask

  function automatic bit [AW-1:0] ra_of(int p);
    logic [NP*AW-1:0] v;
    v = id_ra;
    return v[p*AW +: AW];
  endfunction

  task automatic settle();
    logic [NP*SW-1:0] e_sel;
    logic [NP*XL-1:0] e_opnd;
    #1;
    e_sel  = '0;
    e_opnd = ex_opnd_in;
    for (int p = 0; p < NP; p++) begin
      int hit[$];
      hit = m_st.find_first_index(x) with (x.v && x.rw && x.wa == m_ra[p]);
      if (m_used[p] && m_ra[p] != 0 && hit.size() > 0) begin
        e_sel[p*SW +: SW]  = SW'(hit[0] + 1);
        e_opnd[p*XL +: XL] = fwd_data[hit[0]*XL +: XL];
      end
    end
    // An instruction of age a (EX = 0) is a not-yet-ready load while a+1 < LR.
    e_stall = 1'b0;
    for (int a = 0; a < FS; a++) begin
      ent_t e;
      e = (a == 0) ? m_ex : m_st[a-1];
      if (e.v && e.rw && e.ld && (a + 1) < LR)
        for (int p = 0; p < NP; p++)
          if (id_ra_used[p] && ra_of(p) != 0 && ra_of(p) == e.wa) e_stall = id_valid && !ex_redirect;
    end
    chk("fwd_sel",   64'(fwd_sel),     64'(e_sel));
    chk("opnd_out",  64'(ex_opnd_out), 64'(e_opnd));
    chk("stall_fd",  64'(stall_fd),    64'(e_stall));
    chk("flush_fd",  64'(flush_fd),    64'(ex_redirect));
    chk("flush_de",  64'(flush_de),    64'(ex_redirect));
    chk("stall_cnt", 64'(stall_cnt),   64'(m_scnt));
    chk("flush_cnt", 64'(flush_cnt),   64'(m_fcnt));
  endtask

  task automatic clk_edge();
    @(posedge clk);
    if (rst) begin
      if (e_stall && m_scnt != 32'hFFFF_FFFF) m_scnt++;
      if (ex_redirect && m_fcnt != 32'hFFFF_FFFF) m_fcnt++;
      m_st.push_front(m_ex);
      void'(m_st.pop_back());
      if (e_stall || ex_redirect) begin
        m_ex = '0;
        for (int p = 0; p < NP; p++) m_used[p] = 1'b0;
      end else begin
        m_ex.v  = id_valid;
        m_ex.wa = id_wa;
        m_ex.rw = id_regwen && id_wa != 0;
        m_ex.ld = id_is_load;
        for (int p = 0; p < NP; p++) begin
          m_ra[p]   = ra_of(p);
          m_used[p] = id_ra_used[p] && id_valid;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic drv(input bit v, input bit [AW-1:0] wa, input bit rw, input bit ld,
                     input bit [AW-1:0] ra0, input bit [AW-1:0] ra1, input bit [1:0] used,
                     input bit redir);
    id_valid    = v;
    id_wa       = wa;
    id_regwen   = rw;
    id_is_load  = ld;
    id_ra       = {ra1, ra0};
    id_ra_used  = used;
    ex_redirect = redir;
    ex_opnd_in  = {$urandom, $urandom};
    fwd_data    = {$urandom, $urandom};
  endtask

  initial begin
    rst = 1'b0;
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    m_reset();
    @(negedge clk);
    settle();
    chk("rst_sel",  64'(fwd_sel), 64'(0));
    chk("rst_opnd", 64'(ex_opnd_out), 64'(ex_opnd_in));
    clk_edge();
    rst = 1'b1;

    // back-to-back ALU dependency
    drv(1, 5, 1, 0, 1, 2, 3, 0); settle(); clk_edge();
    drv(1, 6, 1, 0, 5, 1, 3, 0); settle(); clk_edge();
    drv(0, 0, 0, 0, 0, 0, 0, 0); fwd_data[31:0] = 32'h0000_0042; settle();
    chk("b2b_sel",  64'(fwd_sel[1:0]), 64'(2'd1));
    chk("b2b_opnd", 64'(ex_opnd_out[31:0]), 64'(32'h0000_0042));
    clk_edge();

    // two producers of x5 in flight: stage 1 beats stage 2
    drv(1, 5, 1, 0, 0, 0, 0, 0); settle(); clk_edge();
    drv(1, 5, 1, 0, 0, 0, 0, 0); settle(); clk_edge();
    drv(1, 9, 1, 0, 5, 5, 3, 0); settle(); clk_edge();
    drv(0, 0, 0, 0, 0, 0, 0, 0); settle();
    chk("young_sel",  64'(fwd_sel), 64'(4'b0101));
    chk("young_opnd", 64'(ex_opnd_out[63:32]), 64'(fwd_data[31:0]));
    clk_edge();

    // load-use: exactly one stall, then forward from stage 2 on both ports
    drv(1, 7, 1, 1, 0, 0, 0, 0); settle(); clk_edge();
    drv(1, 8, 1, 0, 7, 7, 3, 0); settle(); chk("lu_stall", 64'(stall_fd), 64'(1'b1)); clk_edge();
    drv(1, 8, 1, 0, 7, 7, 3, 0); settle(); chk("lu_release", 64'(stall_fd), 64'(1'b0)); clk_edge();
    drv(0, 0, 0, 0, 0, 0, 0, 0); settle();
    chk("lu_sel", 64'(fwd_sel), 64'(4'b1010));
    chk("lu_cnt", 64'(stall_cnt), 64'(32'd1));
    clk_edge();

    // x0 is never forwarded and never stalls
    drv(1, 0, 1, 0, 0, 0, 0, 0); settle(); clk_edge();
    drv(1, 0, 1, 1, 0, 0, 0, 0); settle(); clk_edge();
    drv(1, 3, 1, 0, 0, 0, 3, 0); settle(); chk("x0_stall", 64'(stall_fd), 64'(1'b0)); clk_edge();
    drv(0, 0, 0, 0, 0, 0, 0, 0); settle();
    chk("x0_sel",  64'(fwd_sel), 64'(0));
    chk("x0_opnd", 64'(ex_opnd_out), 64'(ex_opnd_in));
    clk_edge();

    // redirect coincident with load-use
    drv(1, 9, 1, 1, 0, 0, 0, 0); settle(); clk_edge();
    drv(1, 10, 1, 0, 9, 0, 1, 1); settle();
    chk("rd_flush_fd", 64'(flush_fd), 64'(1'b1));
    chk("rd_flush_de", 64'(flush_de), 64'(1'b1));
    chk("rd_stall",    64'(stall_fd), 64'(1'b0));
    clk_edge();
    drv(0, 0, 0, 0, 0, 0, 0, 0); settle();
    chk("rd_bubble", 64'(fwd_sel), 64'(0));
    chk("rd_cnt",    64'(flush_cnt), 64'(32'd1));
    clk_edge();

    // stall counter saturation
    dut.r_stall_cnt = 32'hFFFF_FFFE;
    m_scnt = 32'hFFFF_FFFE;
    for (int i = 0; i < 2; i++) begin
      drv(1, 7, 1, 1, 0, 0, 0, 0); settle(); clk_edge();
      drv(1, 8, 1, 0, 7, 0, 1, 0); settle(); clk_edge();
    end
    drv(0, 0, 0, 0, 0, 0, 0, 0); settle();
    chk("sat_cnt", 64'(stall_cnt), 64'(32'hFFFF_FFFF));
    clk_edge();

    // reset asserted mid-stall
    drv(1, 7, 1, 1, 0, 0, 0, 0); settle(); clk_edge();
    drv(1, 8, 1, 0, 7, 7, 3, 0); settle(); chk("mid_stall", 64'(stall_fd), 64'(1'b1));
    rst = 1'b0;
    m_reset();
    settle();
    chk("mr_stall", 64'(stall_fd), 64'(1'b0));
    chk("mr_sel",   64'(fwd_sel), 64'(0));
    chk("mr_scnt",  64'(stall_cnt), 64'(0));
    chk("mr_fcnt",  64'(flush_cnt), 64'(0));
    clk_edge();
    rst = 1'b1;

    // random traffic on a small register window to provoke hazards
    for (int i = 0; i < 400; i++) begin
      drv(1'($urandom), AW'($urandom_range(0, 3)), 1'($urandom), $urandom_range(0, 2) == 0,
          AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)), 2'($urandom),
          $urandom_range(0, 7) == 0);
      settle();
      clk_edge();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hazard_fwd_unit.md
Name: hazard_fwd_unit

Overview:
- Parametrised hazard-detection and operand-forwarding unit for the in-order RISC-V pipeline.
- Generalises the fixed two-source, EX/MEM + MEM/WB forwarding to N read ports and F forwarding stages.
- Adds load-use stall generation, branch/jump redirect flush and performance counters.
- Tracks in-flight destinations in its own shadow pipeline; sits beside the decode/execute boundary and drives the EX operand muxes.

Parameters:
- XLEN, 32, operand data width.
- RA_W, 5, register address width.
- NUM_RD_PORTS, 2, source operands per instruction.
- FWD_STAGES, 2, stages after EX that can forward (stage 1 = EX/MEM, stage 2 = MEM/WB, ...); minimum 1.
- LOAD_READY_STAGE, 2, first stage index (1..FWD_STAGES) at which load data is forwardable.
- Localparam SEL_W = clog2(FWD_STAGES+1).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- id_valid  in  1  decode slot holds a real instruction.
- id_ra  in  NUM_RD_PORTS*RA_W  decode source addresses, port p at [p*RA_W +: RA_W].
- id_ra_used  in  NUM_RD_PORTS  per-port "source actually read".
- id_wa  in  RA_W  decode destination address.
- id_regwen  in  1  decode instruction writes the register file.
- id_is_load  in  1  decode instruction is a load.
- ex_redirect  in  1  branch/jump taken, resolved in EX this cycle.
- ex_opnd_in  in  NUM_RD_PORTS*XLEN  register-file operands already latched into EX.
- fwd_data  in  FWD_STAGES*XLEN  result of stage k at slot k-1.
- ex_opnd_out  out  NUM_RD_PORTS*XLEN  forwarded operands to the ALU.
- fwd_sel  out  NUM_RD_PORTS*SEL_W  per port: 0 = no forward, k = from stage k.
- stall_fd  out  1  hold PC and the F/D register; inject a bubble into EX.
- flush_fd  out  1  squash the F/D register.
- flush_de  out  1  squash the D/E register.
- stall_cnt  out  32  cycles stalled, saturating.
- flush_cnt  out  32  redirects taken, saturating.

Behaviour:
- State: EX entry plus stages 1..FWD_STAGES, each {valid, wa, regwen_eff, is_load}.
  - regwen_eff = regwen && wa != 0.
  - EX read-address registers ex_ra[p] and ex_used[p].
- Reset: all entries invalid, ex_ra = 0, ex_used = 0, counters = 0.
  - Consequently stall_fd = flush_fd = flush_de = 0, fwd_sel = 0, ex_opnd_out = ex_opnd_in.
- Forwarding (combinational):
  - For port p with ex_used[p] and ex_ra[p] != 0, pick the lowest k in 1..FWD_STAGES where stage k is valid, regwen_eff, and wa == ex_ra[p].
  - Youngest producer wins. fwd_sel = k; ex_opnd_out[p] = fwd_data slot k-1.
  - If no match, fwd_sel = 0 and ex_opnd_out = ex_opnd_in.
- Load-use stall (combinational):
  - Condition: id_valid, and some position q in {EX = 0, 1..FWD_STAGES-1} holds a valid load with regwen_eff.
  - Its wa equals some used, nonzero id_ra[p].
  - And q+1 < LOAD_READY_STAGE.
  - With defaults this is a load in EX, giving exactly one stall cycle.
- Redirect: ex_redirect drives flush_fd = flush_de = 1 the same cycle and forces stall_fd = 0 (redirect has priority).
- Clock edge:
  - Stages shift every cycle: EX→1→…→FWD_STAGES; the oldest entry drops.
  - If ex_redirect or stall_fd, the EX entry becomes a bubble (valid = 0) and ex_used is cleared.
  - Otherwise the EX entry loads {id_valid, id_wa, id_regwen, id_is_load}, and ex_ra/ex_used load id_ra/(id_ra_used & id_valid).
- Counters:
  - stall_cnt increments on cycles with stall_fd = 1.
  - flush_cnt increments on cycles with ex_redirect = 1.
  - Both saturate at 32'hFFFF_FFFF.
- Reset asserted mid-stall or mid-flush clears all state immediately; outputs return to their reset values without waiting for a clock edge.

Test Plan:
- Back-to-back ALU ops: add x5 then sub x6,x5,x1. Next cycle fwd_sel[0] = 1 and ex_opnd_out[0] = fwd_data slot 0 (e.g. 32'h0000_0042).
- Gap of one instruction (producer in stage 2), then a producer in stage 1 writing the same x5. fwd_sel = 1, showing the youngest producer wins.
- lw x7 then add x8,x7,x7. stall_fd = 1 for exactly 1 cycle, then fwd_sel[0] = fwd_sel[1] = 2; stall_cnt = 1.
- Writes to x0 are in flight and the consumer reads x0. fwd_sel = 0, no stall, ex_opnd_out = ex_opnd_in.
- ex_redirect coincident with a load-use condition. flush_fd = flush_de = 1, stall_fd = 0, next EX entry is a bubble, flush_cnt = 1.
- Preload stall_cnt near saturation: at 32'hFFFF_FFFE, two stall cycles leave it at 32'hFFFF_FFFF. Assert rst low mid-stall: all outputs return to reset values immediately.
